// File: rtl/ctrl_cmd_executor_if.sv
// Command-in, register-bus and command-out signals of ctrl_cmd_executor.
// The slave modport is the executor's view; the master modport drives it.
interface ctrl_cmd_executor_if;
  logic        Command_wr;
  logic [63:0] Command;
  logic        Command_alf;
  logic        Reg_wr;
  logic        Reg_rd;
  logic [19:0] Reg_addr;
  logic [31:0] Reg_wdata;
  logic [31:0] Reg_rdata;
  logic        Reg_ack;
  logic        Command_out_wr;
  logic [63:0] Command_out;
  logic        Command_out_alf;

  modport slave (
    input  Command_wr, Command, Reg_rdata, Reg_ack, Command_out_alf,
    output Command_alf, Reg_wr, Reg_rd, Reg_addr, Reg_wdata, Command_out_wr, Command_out
  );

  modport master (
    output Command_wr, Command, Reg_rdata, Reg_ack, Command_out_alf,
    input  Command_alf, Reg_wr, Reg_rd, Reg_addr, Reg_wdata, Command_out_wr, Command_out
  );
endinterface

// File: rtl/ctrl_cmd_executor.sv
// Executes 64-bit config commands addressed to this MDID on a local register bus
// and forwards all others unchanged; one command in flight behind an input FIFO.
module ctrl_cmd_executor #(
  parameter logic [6:0]  MDID       = 7'd1,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ALF_LEVEL  = 12,
  parameter logic [15:0] TIMEOUT    = 16'd255
) (
  input  logic                 Clk,
  input  logic                 Reset,
  ctrl_cmd_executor_if.slave   bus,
  output logic [31:0]          cmd_in_cnt,
  output logic [31:0]          exec_cnt,
  output logic [31:0]          timeout_cnt,
  output logic [31:0]          drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    ACCESS   = 3'd2,
    WAIT_ACK = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            alf_q, alf_d;
  logic [63:0]     cmd_q, cmd_d, resp_q, resp_d;
  logic [15:0]     timer_q, timer_d;
  logic [31:0]     cmd_in_cnt_q, cmd_in_cnt_d, exec_cnt_q, exec_cnt_d;
  logic [31:0]     timeout_cnt_q, timeout_cnt_d, drop_cnt_q, drop_cnt_d;
  logic            reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic [19:0]     reg_addr_q, reg_addr_d;
  logic [31:0]     reg_wdata_q, reg_wdata_d;
  logic            out_wr_q, out_wr_d;
  logic [63:0]     out_q, out_d;
  logic            full, pop, push, drop, is_local;

  // A full FIFO still accepts a write when the same edge pops an entry.
  always_comb begin
    full          = (count_q == CW'(FIFO_DEPTH));
    pop           = (state_q == IDLE) && (count_q != '0) && !bus.Command_out_alf;
    push          = bus.Command_wr && (!full || pop);
    drop          = bus.Command_wr && full && !pop;
    wr_ptr_d      = push ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
    rd_ptr_d      = pop  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    alf_d         = (count_d >= CW'(ALF_LEVEL));
    cmd_in_cnt_d  = cmd_in_cnt_q + 32'(push);
    drop_cnt_d    = drop_cnt_q + 32'(drop);
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    resp_d        = resp_q;
    timer_d       = timer_q;
    exec_cnt_d    = exec_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    is_local      = cmd_q[63] && (cmd_q[58:52] == MDID);
    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d   = mem_q[rd_ptr_q];
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if (is_local) begin
          state_d = ACCESS;
        end else begin
          resp_d  = cmd_q;
          state_d = RESP;
        end
      end
      ACCESS: begin
        timer_d = 16'd0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.Reg_ack) begin
          resp_d     = {cmd_q[63:61], 1'b1, cmd_q[59:32],
                        cmd_q[59] ? cmd_q[31:0] : bus.Reg_rdata};
          exec_cnt_d = exec_cnt_q + 32'd1;
          state_d    = RESP;
        end else if (timer_q == (TIMEOUT - 16'd1)) begin
          resp_d        = {cmd_q[63:61], 1'b0, cmd_q[59:0]};
          timeout_cnt_d = timeout_cnt_q + 32'd1;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each appears in its own state's cycle.
  always_comb begin
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    out_wr_d    = 1'b0;
    out_d       = 64'd0;
    if (state_d == ACCESS) begin
      reg_wr_d    = cmd_q[59];
      reg_rd_d    = !cmd_q[59];
      reg_addr_d  = cmd_q[51:32];
      reg_wdata_d = cmd_q[31:0];
    end else if (state_d == RESP) begin
      out_wr_d = 1'b1;
      out_d    = resp_d;
    end else begin
      out_wr_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      alf_q         <= 1'b0;
      cmd_q         <= 64'd0;
      resp_q        <= 64'd0;
      timer_q       <= 16'd0;
      cmd_in_cnt_q  <= 32'd0;
      exec_cnt_q    <= 32'd0;
      timeout_cnt_q <= 32'd0;
      drop_cnt_q    <= 32'd0;
      reg_wr_q      <= 1'b0;
      reg_rd_q      <= 1'b0;
      reg_addr_q    <= 20'd0;
      reg_wdata_q   <= 32'd0;
      out_wr_q      <= 1'b0;
      out_q         <= 64'd0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      alf_q         <= alf_d;
      cmd_q         <= cmd_d;
      resp_q        <= resp_d;
      timer_q       <= timer_d;
      cmd_in_cnt_q  <= cmd_in_cnt_d;
      exec_cnt_q    <= exec_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      reg_wr_q      <= reg_wr_d;
      reg_rd_q      <= reg_rd_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      out_wr_q      <= out_wr_d;
      out_q         <= out_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.Command;
    end
  end

  assign bus.Command_alf    = alf_q;
  assign bus.Reg_wr         = reg_wr_q;
  assign bus.Reg_rd         = reg_rd_q;
  assign bus.Reg_addr       = reg_addr_q;
  assign bus.Reg_wdata      = reg_wdata_q;
  assign bus.Command_out_wr = out_wr_q;
  assign bus.Command_out    = out_q;
  assign cmd_in_cnt         = cmd_in_cnt_q;
  assign exec_cnt           = exec_cnt_q;
  assign timeout_cnt        = timeout_cnt_q;
  assign drop_cnt           = drop_cnt_q;
endmodule

// File: tb/tb_ctrl_cmd_executor.sv
// Randomized self-checking bench for ctrl_cmd_executor against an in-order
// command-queue reference model with a register-bus responder.
module tb_ctrl_cmd_executor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ctrl_cmd_executor_if bus_if();
  logic [31:0] cmd_in_cnt, exec_cnt, timeout_cnt, drop_cnt;

  ctrl_cmd_executor #(
    .MDID(7'd1), .FIFO_DEPTH(16), .ALF_LEVEL(12), .TIMEOUT(16'd8)
  ) dut (
    .Clk(clk), .Reset(rst), .bus(bus_if),
    .cmd_in_cnt(cmd_in_cnt), .exec_cnt(exec_cnt),
    .timeout_cnt(timeout_cnt), .drop_cnt(drop_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] model_q[$];
  logic [31:0] m_in = 0, m_exec = 0, m_to = 0, m_drop = 0;
  bit          pending = 0;
  logic [63:0] exp_resp;
  int          exp_cyc = 0;
  int          ack_at = -1;
  logic [31:0] ack_data;
  int          force_d = -1;
  bit          force_rd_en = 0;
  logic [31:0] force_rd = 32'd0;
  bit          no_ack = 0;
  logic [63:0] last_out = 64'd0;
  int          last_out_cyc = 0;
  int          out_cnt = 0;
  int          strobe_cnt = 0;
  int          sent_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_local(input logic [63:0] c);
    return c[63] && (c[58:52] == 7'd1);
  endfunction

  function automatic logic [63:0] rand_cmd();
    logic [2:0] pos;
    logic [6:0] id;
    case ($urandom_range(0, 5))
      0:       pos = 3'b101;
      1:       pos = 3'b111;
      2:       pos = 3'b110;
      3:       pos = 3'b100;
      default: pos = 3'($urandom_range(0, 3));
    endcase
    id = ($urandom_range(0, 9) < 6) ? 7'd1 : 7'($urandom_range(2, 127));
    return {pos, 1'($urandom), 1'($urandom), id, 20'($urandom), 32'($urandom)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor and register responder; the reference model is an in-order queue.
  initial begin
    logic [63:0] c;
    logic [31:0] rd;
    int d;
    bus_if.Reg_ack   = 1'b0;
    bus_if.Reg_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst && (bus_if.Reg_wr || bus_if.Reg_rd)) begin
        strobe_cnt++;
        check_eq("strobe_has_cmd", 64'(model_q.size() != 0), 64'd1);
        if (model_q.size() != 0) begin
          c = model_q[0];
          check_eq("strobe_local", 64'(is_local(c)), 64'd1);
          check_eq("strobe_kind", {62'd0, bus_if.Reg_wr, bus_if.Reg_rd}, c[59] ? 64'd2 : 64'd1);
          check_eq("strobe_addr", 64'(bus_if.Reg_addr), 64'(c[51:32]));
          check_eq("strobe_wdata", 64'(bus_if.Reg_wdata), 64'(c[31:0]));
          d  = no_ack ? 99 : ((force_d >= 0) ? force_d : $urandom_range(0, 11));
          rd = force_rd_en ? force_rd : $urandom;
          if (!no_ack) begin
            ack_at   = cyc + d;
            ack_data = rd;
          end
          if (d >= 1 && d <= 8) begin
            exp_resp = {c[63:61], 1'b1, c[59:32], c[59] ? c[31:0] : rd};
            exp_cyc  = cyc + d + 1;
            m_exec++;
          end else begin
            exp_resp = {c[63:61], 1'b0, c[59:0]};
            exp_cyc  = cyc + 9;
            m_to++;
          end
          pending = 1;
        end
      end
      if (cyc == ack_at) begin
        bus_if.Reg_ack   = 1'b1;
        bus_if.Reg_rdata = ack_data;
      end else begin
        bus_if.Reg_ack   = 1'b0;
        bus_if.Reg_rdata = $urandom;
      end
      if (!rst && bus_if.Command_out_wr) begin
        last_out     = bus_if.Command_out;
        last_out_cyc = cyc;
        out_cnt++;
        check_eq("out_has_cmd", 64'(model_q.size() != 0), 64'd1);
        if (model_q.size() != 0) begin
          c = model_q.pop_front();
          if (is_local(c)) begin
            check_eq("out_after_strobe", 64'(pending), 64'd1);
            check_eq("out_resp", bus_if.Command_out, exp_resp);
            check_eq("out_latency", 64'(cyc), 64'(exp_cyc));
            pending = 0;
          end else begin
            check_eq("out_fwd", bus_if.Command_out, c);
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] c);
    @(negedge clk);
    bus_if.Command_wr = 1'b1;
    bus_if.Command    = c;
    sent_cyc          = cyc;
    model_q.push_back(c);
    m_in++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_if.Command_wr = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((model_q.size() != 0 || pending) && n < 3000) begin
      @(negedge clk);
      bus_if.Command_wr = 1'b0;
      n++;
    end
    check_eq(tag, 64'(model_q.size()), 64'd0);
    idle(4);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_in"},   64'(cmd_in_cnt),  64'(m_in));
    check_eq({tag, "_exec"}, 64'(exec_cnt),    64'(m_exec));
    check_eq({tag, "_to"},   64'(timeout_cnt), 64'(m_to));
    check_eq({tag, "_drop"}, 64'(drop_cnt),    64'(m_drop));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_alf"},   64'(bus_if.Command_alf),    64'd0);
    check_eq({tag, "_wr"},    64'(bus_if.Reg_wr),         64'd0);
    check_eq({tag, "_rd"},    64'(bus_if.Reg_rd),         64'd0);
    check_eq({tag, "_addr"},  64'(bus_if.Reg_addr),       64'd0);
    check_eq({tag, "_wdata"}, 64'(bus_if.Reg_wdata),      64'd0);
    check_eq({tag, "_owr"},   64'(bus_if.Command_out_wr), 64'd0);
    check_eq({tag, "_out"},   bus_if.Command_out,         64'd0);
    check_counters(tag);
  endtask

  initial begin
    int s0;
    int o0;
    int n;
    bus_if.Command_wr      = 1'b0;
    bus_if.Command         = 64'd0;
    bus_if.Command_out_alf = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");

    // Local write, ack two cycles after the strobe.
    force_d = 2;
    send(64'hA81_00010_DEADBEEF);
    drain("t1_drain");
    check_eq("t1_out", last_out, 64'hB81_00010_DEADBEEF);
    check_eq("t1_lat", 64'(last_out_cyc), 64'(sent_cyc + 6));
    check_eq("t1_exec", 64'(exec_cnt), 64'd1);

    // Local read, earliest ack.
    force_d = 1; force_rd_en = 1; force_rd = 32'h12345678;
    send(64'hA01_00020_00000000);
    drain("t2_drain");
    check_eq("t2_out", last_out, 64'hB01_00020_12345678);
    check_eq("t2_lat", 64'(last_out_cyc), 64'(sent_cyc + 5));
    force_rd_en = 0;

    // Foreign MDID is forwarded untouched.
    s0 = strobe_cnt;
    send(64'hA05_00030_CAFEF00D);
    drain("t3_drain");
    check_eq("t3_out", last_out, 64'hA05_00030_CAFEF00D);
    check_eq("t3_lat", 64'(last_out_cyc), 64'(sent_cyc + 3));
    check_eq("t3_nostrobe", 64'(strobe_cnt - s0), 64'd0);
    check_eq("t3_exec", 64'(exec_cnt), 64'd2);

    // Timeout with a late ack.
    force_d = 10;
    send(64'hB81_00040_11223344);
    drain("t4_drain");
    idle(8);
    check_eq("t4_out", last_out, 64'hA81_00040_11223344);
    check_eq("t4_lat", 64'(last_out_cyc), 64'(sent_cyc + 12));
    check_eq("t4_to", 64'(timeout_cnt), 64'd1);
    check_eq("t4_exec", 64'(exec_cnt), 64'd2);
    force_d = -1;
    check_counters("t4");

    // Randomized traffic without overflow, with downstream backpressure.
    repeat (1500) begin
      @(negedge clk);
      bus_if.Command_out_alf = ($urandom_range(0, 7) == 0);
      if (model_q.size() < 15 && $urandom_range(0, 2) == 0) begin
        bus_if.Command_wr = 1'b1;
        bus_if.Command    = rand_cmd();
        model_q.push_back(bus_if.Command);
        m_in++;
      end else begin
        bus_if.Command_wr = 1'b0;
      end
    end
    bus_if.Command_out_alf = 1'b0;
    drain("rand_drain");
    check_counters("rand");

    // Fill under backpressure: almost-full at 12, four drops, in-order release.
    o0 = out_cnt;
    bus_if.Command_out_alf = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) check_eq("t5_alf", 64'(bus_if.Command_alf), 64'(i >= 12));
      bus_if.Command_wr = 1'b1;
      bus_if.Command    = rand_cmd();
      if (i < 16) begin
        model_q.push_back(bus_if.Command);
        m_in++;
      end else begin
        m_drop++;
      end
    end
    @(negedge clk);
    bus_if.Command_wr = 1'b0;
    check_eq("t5_alf_full", 64'(bus_if.Command_alf), 64'd1);
    check_eq("t5_drop", 64'(drop_cnt), 64'd4);
    bus_if.Command_out_alf = 1'b0;
    drain("t5_drain");
    check_eq("t5_outs", 64'(out_cnt - o0), 64'd16);
    check_counters("t5");

    // Reset while waiting for an ack discards the command and flushes the FIFO.
    no_ack = 1;
    s0 = strobe_cnt;
    send(64'hA81_00050_55AA55AA);
    send(64'hA05_00060_00000001);
    send(64'hA05_00070_00000002);
    n = 0;
    while (strobe_cnt == s0 && n < 50) begin
      idle(1);
      n++;
    end
    check_eq("t6_strobe", 64'(strobe_cnt - s0), 64'd1);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    bus_if.Command_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    pending = 0;
    ack_at = -1;
    no_ack = 0;
    m_in = 0; m_exec = 0; m_to = 0; m_drop = 0;
    check_idle_outputs("t6_rst");
    o0 = out_cnt;
    idle(20);
    check_eq("t6_noresp", 64'(out_cnt - o0), 64'd0);
    send(64'h605_00080_0BADF00D);
    drain("t6_drain");
    check_eq("t6_out", last_out, 64'h605_00080_0BADF00D);
    check_eq("t6_lat", 64'(last_out_cyc), 64'(sent_cyc + 3));
    check_eq("t6_in", 64'(cmd_in_cnt), 64'd1);
    check_counters("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
